board_lights_animator: RTL and testbench

Parametrised LED refresher for the game board. On each refresh request it decodes the board cell vector into one LED per cell per player. When the game has ended, it blinks the winning line (or the whole board on a tie) for a programmable number of toggles at a programmable rate, then clears or restores the LEDs. It sits between the game FSM, which issues requests and consumes `refresh_done`, and the board LED pins, and supports arbitrary cell counts.

---
 rtl/board_pkg.sv | 30 +++
 rtl/board_lights_animator_timer.sv | 42 ++++
 rtl/board_lights_animator.sv | 126 ++++++++++++
 tb/tb_board_lights_animator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and the per-cell LED decode for the board lights animator.
package board_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10,
    CELL_BOTH  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    RES_PLAY = 2'b00,
    RES_WIN  = 2'b01,
    RES_TIE  = 2'b10,
    RES_RSVD = 2'b11
  } result_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    BLINK = 2'b10
  } lights_state_t;

  // Returns {o_led, x_led} for one cell; the caller replicates it across all CELLS.
  function automatic logic [1:0] decode_cells(input cell_t code);
    decode_cells = {(code == CELL_O) || (code == CELL_BOTH),
                    (code == CELL_X) || (code == CELL_BOTH)};
  endfunction

endpackage

// File: rtl/board_lights_animator_timer.sv
// Blink pacing: prescaler down-counter feeding a toggle down-counter.
module lights_blink_timer
  import board_pkg::*;
#(
  parameter int BLINK_TOGGLES = 20,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick,
  output logic last
);

  localparam int TW = $clog2(BLINK_TOGGLES + 1);
  localparam int PW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [TW-1:0] toggles_left;
  logic [PW-1:0] prescaler;

  // Idle when toggles_left is 0; both counters stop there instead of wrapping.
  assign tick = (toggles_left != '0) && (prescaler == '0);
  assign last = tick && (toggles_left == TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      toggles_left <= '0;
      prescaler    <= '0;
    end else if (start) begin
      toggles_left <= TW'(BLINK_TOGGLES);
      prescaler    <= PW'(HOLD_CYCLES - 1);
    end else if (toggles_left != '0) begin
      if (prescaler == '0) begin
        prescaler    <= PW'(HOLD_CYCLES - 1);
        toggles_left <= toggles_left - TW'(1);
      end else begin
        prescaler <= prescaler - PW'(1);
      end
    end
  end

endmodule

// File: rtl/board_lights_animator.sv
// Board LED refresher: decodes cells to LEDs and blinks the result when the game ends.
//   state | meaning
//   IDLE  | lights held, waiting for refresh_req
//   LOAD  | drive decoded board, decide plain refresh or animation
//   BLINK | toggle result mask on each timer tick until the last one
module board_lights_animator
  import board_pkg::*;
#(
  parameter int CELLS         = 9,
  parameter int BLINK_TOGGLES = 20,
  parameter int HOLD_CYCLES   = 1,
  parameter bit CLEAR_AT_END  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refresh_req,
  input  logic [CELLS-1:0][1:0] cells,
  input  logic [1:0]            result_kind,
  input  logic                  win_player,
  input  logic [CELLS-1:0]      win_mask,
  output logic [2*CELLS-1:0]    lights,
  output logic                  refresh_done,
  output logic                  busy
);

  localparam int LW = 2 * CELLS;

  lights_state_t         state, state_n;
  logic [CELLS-1:0][1:0] cells_q;
  result_kind_t          kind_q;
  logic                  player_q;
  logic [CELLS-1:0]      win_q;
  logic [LW-1:0]         base_q, base_n, lights_n, decoded, toggle_mask;
  logic                  done_n, capture, start, tick, last;

  for (genvar i = 0; i < CELLS; i++) begin : g_dec
    assign {decoded[CELLS+i], decoded[i]} = decode_cells(cell_t'(cells_q[i]));
  end

  always_comb begin
    toggle_mask = '0;
    case (kind_q)
      RES_TIE: toggle_mask = '1;
      RES_WIN: toggle_mask = player_q ? {{CELLS{1'b0}}, win_q} : {win_q, {CELLS{1'b0}}};
      default: toggle_mask = '0;
    endcase
  end

  lights_blink_timer #(
    .BLINK_TOGGLES(BLINK_TOGGLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .tick (tick),
    .last (last)
  );

  always_comb begin
    state_n  = state;
    lights_n = lights;
    base_n   = base_q;
    done_n   = 1'b0;
    capture  = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_req) begin
          capture = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        lights_n = decoded;
        base_n   = decoded;
        if ((kind_q == RES_WIN) || (kind_q == RES_TIE)) begin
          start   = 1'b1;
          state_n = BLINK;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      BLINK: begin
        if (tick) begin
          if (last) begin
            lights_n = CLEAR_AT_END ? '0 : base_q;
            done_n   = 1'b1;
            state_n  = IDLE;
          end else begin
            lights_n = lights ^ toggle_mask;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lights       <= '0;
      refresh_done <= 1'b0;
      busy         <= 1'b0;
      base_q       <= '0;
      cells_q      <= '0;
      kind_q       <= RES_PLAY;
      player_q     <= 1'b0;
      win_q        <= '0;
    end else begin
      state        <= state_n;
      lights       <= lights_n;
      refresh_done <= done_n;
      busy         <= (state_n != IDLE);
      base_q       <= base_n;
      if (capture) begin
        cells_q  <= cells;
        kind_q   <= result_kind_t'(result_kind);
        player_q <= win_player;
        win_q    <= win_mask;
      end
    end
  end

endmodule

// File: tb/tb_board_lights_animator.sv
// Scoreboard bench: clear-at-end and restore-at-end instances against a timeline model.
module tb_board_lights_animator;

  localparam int N  = 9;
  localparam int BT = 4;
  localparam int HC = 2;

  typedef struct {
    int          cyc;
    logic [17:0] l;
  } done_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            refresh_req;
  logic [N-1:0][1:0] cells;
  logic [1:0]      result_kind;
  logic            win_player;
  logic [N-1:0]    win_mask;
  logic [2*N-1:0]  lights0, lights1;
  logic            done0, done1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [17:0] exp_l0 [int];
  logic [17:0] exp_l1 [int];
  logic        exp_b  [int];
  done_t       dq0[$];
  done_t       dq1[$];
  logic [17:0] cur0 = '0, cur1 = '0;
  logic        curb = 1'b0;

  board_lights_animator #(.CELLS(N), .BLINK_TOGGLES(BT), .HOLD_CYCLES(HC), .CLEAR_AT_END(1'b1)) dut_clr (
    .clk(clk), .rst(rst), .refresh_req(refresh_req), .cells(cells), .result_kind(result_kind),
    .win_player(win_player), .win_mask(win_mask), .lights(lights0), .refresh_done(done0), .busy(busy0));

  board_lights_animator #(.CELLS(N), .BLINK_TOGGLES(BT), .HOLD_CYCLES(HC), .CLEAR_AT_END(1'b0)) dut_rst (
    .clk(clk), .rst(rst), .refresh_req(refresh_req), .cells(cells), .result_kind(result_kind),
    .win_player(win_player), .win_mask(win_mask), .lights(lights1), .refresh_done(done1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_done(input string name, input logic d, input logic [17:0] l, inout done_t q[$]);
    done_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_missing cyc=%0d actual=none required=%0d", name, cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (d) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected cyc=%0d actual=1 required=0", name, cyc);
      end else begin
        e = q.pop_front();
        check({name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({name, "_lights"}, {14'd0, l}, {14'd0, e.l});
      end
    end
  endtask

  // Monitor: compares every cycle against the expected timeline and pops done events.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (exp_l0.exists(cyc)) cur0 = exp_l0[cyc];
      if (exp_l1.exists(cyc)) cur1 = exp_l1[cyc];
      if (exp_b.exists(cyc))  curb = exp_b[cyc];
      check("lights_clr", {14'd0, lights0}, {14'd0, cur0});
      check("lights_rst", {14'd0, lights1}, {14'd0, cur1});
      check("busy_clr", {31'd0, busy0}, {31'd0, curb});
      check("busy_rst", {31'd0, busy1}, {31'd0, curb});
      check_done("done_clr", done0, lights0, dq0);
      check_done("done_rst", done1, lights1, dq1);
    end
  end

  // Reference model: expected lights/busy timeline for a request sampled at edge e.
  task automatic model(input int e, input logic [N-1:0][1:0] c, input logic [1:0] k,
                       input logic p, input logic [N-1:0] m, output int dcyc);
    logic [17:0] base, mask;
    done_t d;
    base = '0;
    for (int i = 0; i < N; i++) begin
      base[i]     = (c[i] == 2'b01) || (c[i] == 2'b11);
      base[N + i] = (c[i] == 2'b10) || (c[i] == 2'b11);
    end
    exp_b[e] = 1'b1;
    exp_l0[e + 1] = base;
    exp_l1[e + 1] = base;
    if (k == 2'b01 || k == 2'b10) begin
      mask = (k == 2'b10) ? 18'h3ffff : (p ? {9'd0, m} : {m, 9'd0});
      for (int t = 1; t < BT; t++) begin
        exp_l0[e + 1 + t * HC] = (t % 2 == 1) ? (base ^ mask) : base;
        exp_l1[e + 1 + t * HC] = (t % 2 == 1) ? (base ^ mask) : base;
      end
      dcyc = e + 1 + BT * HC;
      exp_l0[dcyc] = '0;
      exp_l1[dcyc] = base;
      d.cyc = dcyc; d.l = '0;   dq0.push_back(d);
      d.cyc = dcyc; d.l = base; dq1.push_back(d);
    end else begin
      dcyc = e + 1;
      d.cyc = dcyc; d.l = base; dq0.push_back(d); dq1.push_back(d);
    end
    exp_b[dcyc] = 1'b0;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) cells[i] = 2'($urandom_range(0, 3));
    result_kind = 2'($urandom_range(0, 3));
    win_player  = 1'($urandom_range(0, 1));
    win_mask    = 9'($urandom);
  endtask

  // Called at a negedge while the model says the DUT is IDLE.
  task automatic issue(input logic [N-1:0][1:0] c, input logic [1:0] k, input logic p,
                       input logic [N-1:0] m, input bit drop, output int e, output int dcyc);
    cells = c; result_kind = k; win_player = p; win_mask = m;
    refresh_req = 1'b1;
    e = cyc + 1;
    model(e, c, k, p, m, dcyc);
    @(negedge clk);
    refresh_req = 1'b0;
    scramble();
    if (drop && dcyc > e + 4) begin
      while (cyc < e + 3) @(negedge clk);
      refresh_req = 1'b1;
      scramble();
      @(negedge clk);
      refresh_req = 1'b0;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic prune(input int r);
    int ks[$];
    ks = {};
    foreach (exp_l0[i]) if (i > r) ks.push_back(i);
    foreach (ks[j]) exp_l0.delete(ks[j]);
    ks = {};
    foreach (exp_l1[i]) if (i > r) ks.push_back(i);
    foreach (ks[j]) exp_l1.delete(ks[j]);
    ks = {};
    foreach (exp_b[i]) if (i > r) ks.push_back(i);
    foreach (ks[j]) exp_b.delete(ks[j]);
  endtask

  initial begin
    logic [N-1:0][1:0] c;
    int e, d;
    rst = 1'b1; refresh_req = 1'b0;
    cells = '0; result_kind = '0; win_player = 1'b0; win_mask = '0;
    exp_l0[1] = '0; exp_l1[1] = '0; exp_b[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain refresh: cell0=X, cell4=O, cell8=both -> bits 0,8,13,17
    c = '0; c[0] = 2'b01; c[4] = 2'b10; c[8] = 2'b11;
    issue(c, 2'b00, 1'b0, 9'h000, 1'b0, e, d);
    wait_until(d);
    check("plain_base", {14'd0, lights0}, 32'h22101);
    repeat (2) @(negedge clk);

    // X win on row 0, with a dropped request during BLINK
    issue(c, 2'b01, 1'b1, 9'b000000111, 1'b1, e, d);
    wait_until(d);
    @(negedge clk);

    // O win on column 1, back-to-back with the next one
    issue(c, 2'b01, 1'b0, 9'b010010010, 1'b0, e, d);
    wait_until(d);

    // Tie on a full board, issued in the done cycle
    for (int i = 0; i < N; i++) c[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    issue(c, 2'b10, 1'b0, 9'h000, 1'b0, e, d);
    wait_until(d);

    // Reserved result kind acts like in-play
    issue(c, 2'b11, 1'b1, 9'h1ff, 1'b0, e, d);
    wait_until(d);
    @(negedge clk);

    // Abort: reset sampled at edge 5 of an animation
    issue(c, 2'b01, 1'b1, 9'b000000111, 1'b0, e, d);
    wait_until(e + 4);
    rst = 1'b1;
    prune(e + 5);
    exp_l0[e + 5] = '0; exp_l1[e + 5] = '0; exp_b[e + 5] = 1'b0;
    dq0.delete(); dq1.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized refreshes
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) c[i] = 2'($urandom_range(0, 3));
      issue(c, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom),
            1'($urandom_range(0, 1)), e, d);
      wait_until(d);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    if (dq0.size() != 0 || dq1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_pending actual=%0d required=0", dq0.size() + dq1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
